// File: rtl/mdu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pipe_pkg
// Purpose  : Shared definitions for the multiply/divide unit: MDU op codes,
//            FSM state encoding and small op-classification helpers.
// Ports    : (package, no ports)
// Revision : 1.0  initial release
// ============================================================================
package mdu_pipe_pkg;

  // Op codes driven by E-stage control on mdu_pipe.op
  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle latency
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: is_long_op = 1'b1;
      default:                                  is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module   : mdu_calc
// Purpose  : Combinational datapath of the MDU. Produces the 2*WIDTH result
//            {hi,lo} for every multi-cycle op and flags division by zero.
// Ports    : op       in   4        operation code
//            a, b     in   WIDTH    operands rs / rt
//            hi, lo   in   WIDTH    current architectural HI/LO
//            result   out  2*WIDTH  {hi,lo} value to commit
//            div_zero out  1        DIV/DIVU with b == 0
// Revision : 1.0  initial release
// ============================================================================
module mdu_calc #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);
  import mdu_pipe_pkg::*;

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [2*WIDTH-1:0] w_sprod, w_uprod;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_udiv_d, w_sdiv_d;
  logic [WIDTH-1:0]   w_uq, w_ur, w_mq, w_mr, w_sq, w_sr;

  always_comb begin
    w_hilo = {hi, lo};

    // Products are formed at 2*WIDTH so the low 2*WIDTH bits are exact for
    // both the sign-extended and zero-extended interpretation.
    w_a_sx  = {{WIDTH{a[WIDTH-1]}}, a};
    w_b_sx  = {{WIDTH{b[WIDTH-1]}}, b};
    w_a_zx  = {{WIDTH{1'b0}}, a};
    w_b_zx  = {{WIDTH{1'b0}}, b};
    w_sprod = w_a_sx * w_b_sx;
    w_uprod = w_a_zx * w_b_zx;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend sign. A zero divisor is replaced by 1
    // only to keep the divider defined; the result is discarded anyway.
    w_a_neg  = a[WIDTH-1];
    w_b_neg  = b[WIDTH-1];
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
    w_udiv_d = (b == '0) ? c_one : b;
    w_sdiv_d = (b == '0) ? c_one : w_b_mag;
    w_uq     = a / w_udiv_d;
    w_ur     = a % w_udiv_d;
    w_mq     = w_a_mag / w_sdiv_d;
    w_mr     = w_a_mag % w_sdiv_d;
    w_sq     = (w_a_neg ^ w_b_neg) ? -w_mq : w_mq;
    w_sr     = w_a_neg ? -w_mr : w_mr;

    result = w_hilo;
    case (op)
      MDU_MULT:  result = w_sprod;
      MDU_MULTU: result = w_uprod;
      MDU_DIV:   result = {w_sr, w_sq};
      MDU_DIVU:  result = {w_ur, w_uq};
      MDU_MADD:  result = w_hilo + w_sprod;
      MDU_MADDU: result = w_hilo + w_uprod;
      MDU_MSUB:  result = w_hilo - w_sprod;
      MDU_MSUBU: result = w_hilo - w_uprod;
      default:   result = w_hilo;
    endcase

    div_zero = is_div_op(op) && (b == '0);
  end

endmodule
`default_nettype wire

// File: rtl/mdu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pipe
// Purpose  : Pipelined-CPU multiply/divide unit. Holds HI/LO, runs
//            MULT/DIV/MADD/MSUB families with configurable latency and
//            supports cancelling an in-flight op without touching HI/LO.
// Ports    : clk     in   1      rising-edge clock
//            reset   in   1      asynchronous, active-low
//            start   in   1      one-cycle issue strobe
//            op      in   4      MDU_* op code
//            a, b    in   WIDTH  operands rs / rt
//            cancel  in   1      kill in-flight op / suppress same-cycle start
//            busy    out  1      operation in flight (registered)
//            hi, lo  out  WIDTH  architectural HI / LO
// Revision : 1.0  initial release
// ============================================================================
module mdu_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pipe_pkg::*;

  localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_mul_lat = c_cnt_w'(MUL_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_lat = c_cnt_w'(DIV_CYCLES);

  mdu_state_e         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_pend;
  logic               r_pend_ok;   // cleared for divide-by-zero: commit nothing
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [2*WIDTH-1:0] w_result;
  logic               w_div_zero;
  logic               w_issue;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (r_hi),
    .lo       (r_lo),
    .result   (w_result),
    .div_zero (w_div_zero)
  );

  assign w_issue = start & ~cancel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_ok <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            if (is_long_op(op)) begin
              // Accumulate ops see the committed {hi,lo} here because issue
              // is only possible from IDLE.
              r_pend    <= w_result;
              r_pend_ok <= ~w_div_zero;
              r_cnt     <= is_div_op(op) ? c_div_lat : c_mul_lat;
              r_state   <= ST_RUN;
            end else if (op == MDU_MTHI) begin
              r_hi <= a;
            end else if (op == MDU_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_RUN: begin
          // start is never expected here; it is deliberately ignored.
          if (cancel) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_ok <= 1'b0;
          end else if (r_cnt == c_cnt_w'(1)) begin
            if (r_pend_ok) begin
              r_hi <= r_pend[2*WIDTH-1:WIDTH];
              r_lo <= r_pend[WIDTH-1:0];
            end
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_ok <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu_pipe
// Purpose  : Self-checking bench for mdu_pipe (default config plus a
//            WIDTH=16 / MUL_CYCLES=1 / DIV_CYCLES=3 instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_pipe;
  import mdu_pipe_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi, lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, cancel, busy;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        start16, cancel16, busy16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  mdu_pipe u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_pipe #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .cancel(cancel16), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  // The hazard unit must never issue while the unit is busy.
  always @(posedge clk) begin
    if (reset && busy && start) begin
      errors++;
      $display("FAIL start_in_run: start=1 while busy=1, required start=0");
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] o, input logic [31:0] x, y,
                         input logic [31:0] ph, pl, eh, el, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = x; v.b = y;
    v.pre_hi = ph; v.pre_lo = pl; v.exp_hi = eh; v.exp_lo = el; v.lat = lat;
    vecs.push_back(v);
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op = MDU_MTHI; a = h; @(negedge clk);
    op = MDU_MTLO; a = l; @(negedge clk);
    start = 1'b0; op = MDU_NOP; a = '0;
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, y,
                        input logic [31:0] eh, el, input int lat);
    exp_t e;
    int   n;
    e.name = name; e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y; @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    e = sb.pop_front();
    check({e.name, "_busy_cycles"}, 64'(n), 64'(e.lat));
    check({e.name, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
    check({e.name, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
  endtask

  task automatic run16(input string name, input logic [3:0] o, input logic [15:0] x, y,
                       input logic [15:0] eh, el, input int lat);
    exp_t e;
    int   n;
    e.name = name; e.hi = {16'h0, eh}; e.lo = {16'h0, el}; e.lat = lat;
    sb.push_back(e);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y; @(negedge clk);
    start16 = 1'b0; op16 = MDU_NOP;
    n = 0;
    while (busy16 && n < 100) begin n++; @(negedge clk); end
    e = sb.pop_front();
    check({e.name, "_busy_cycles"}, 64'(n), 64'(e.lat));
    check({e.name, "_hi"}, {48'h0, hi16}, {32'h0, e.hi});
    check({e.name, "_lo"}, {48'h0, lo16}, {32'h0, e.lo});
  endtask

  initial begin
    start = 1'b0; cancel = 1'b0; op = MDU_NOP; a = '0; b = '0;
    start16 = 1'b0; cancel16 = 1'b0; op16 = MDU_NOP; a16 = '0; b16 = '0;

    //            name             op         a             b             pre_hi        pre_lo        exp_hi        exp_lo        lat
    add_vec("mult_neg3x5",     MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    add_vec("mult_neg1xneg1",  MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h00000001, 5);
    add_vec("multu_max",       MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 5);
    add_vec("div_neg7_2",      MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    add_vec("div_7_neg2",      MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10);
    add_vec("div_neg7_neg2",   MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000003, 10);
    add_vec("divu_7_2",        MDU_DIVU,  32'h00000007, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'h00000003, 10);
    add_vec("divu_big",        MDU_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'h7FFFFFFC, 10);
    add_vec("div_by_zero",     MDU_DIV,   32'h00000005, 32'h00000000, 32'h00000012, 32'h00000034, 32'h00000012, 32'h00000034, 10);
    add_vec("divu_by_zero",    MDU_DIVU,  32'h00000009, 32'h00000000, 32'h000000AB, 32'h000000CD, 32'h000000AB, 32'h000000CD, 10);
    add_vec("madd_signed",     MDU_MADD,  32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h0000000A, 32'h00000000, 32'h00000004, 5);
    add_vec("madd_hi_acc",     MDU_MADD,  32'h00000002, 32'h00000003, 32'h00000010, 32'h00000000, 32'h00000010, 32'h00000006, 5);
    add_vec("msubu_wrap",      MDU_MSUBU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    add_vec("maddu_carry",     MDU_MADDU, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5);
    add_vec("msub_borrow",     MDU_MSUB,  32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset_busy",   {63'h0, busy},   64'h0);
    check("reset_hi",     {32'h0, hi},     64'h0);
    check("reset_lo",     {32'h0, lo},     64'h0);
    check("reset_busy16", {63'h0, busy16}, 64'h0);
    check("reset_hi16",   {48'h0, hi16},   64'h0);

    // MTHI / MTLO visible the cycle after start, never busy
    start = 1'b1; op = MDU_MTHI; a = 32'hA5A55A5A; @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    check("mthi_hi",   {32'h0, hi},   64'hA5A55A5A);
    check("mthi_busy", {63'h0, busy}, 64'h0);
    start = 1'b1; op = MDU_MTLO; a = 32'h0F0F1234; @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    check("mtlo_lo", {32'h0, lo}, 64'h0F0F1234);
    check("mtlo_hi_kept", {32'h0, hi}, 64'hA5A55A5A);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
    end

    // Chained accumulate, issued back-to-back in the first idle cycle
    set_hilo(32'h0, 32'hFFFFFFFF);
    run_op("chain_maddu", MDU_MADDU, 32'h1, 32'h1, 32'h1, 32'h0, 5);
    run_op("chain_msub",  MDU_MSUB,  32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 5);

    // Cancel on the 3rd busy cycle
    set_hilo(32'h11, 32'h22);
    start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4; @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    @(negedge clk);
    @(negedge clk);
    check("cancel_busy_before", {63'h0, busy}, 64'h1);
    cancel = 1'b1; @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_after", {63'h0, busy}, 64'h0);
    check("cancel_hi", {32'h0, hi}, 64'h11);
    check("cancel_lo", {32'h0, lo}, 64'h22);
    repeat (8) @(negedge clk);
    check("cancel_lo_later", {32'h0, lo}, 64'h22);

    // start and cancel in the same cycle: nothing happens
    start = 1'b1; cancel = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4; @(negedge clk);
    check("startcancel_busy", {63'h0, busy}, 64'h0);
    op = MDU_MTHI; a = 32'hDEADBEEF; @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = MDU_NOP;
    check("startcancel_mthi_hi", {32'h0, hi}, 64'h11);
    check("startcancel_lo", {32'h0, lo}, 64'h22);
    run_op("post_cancel_mult", MDU_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5);

    // Asynchronous reset in the middle of a divide
    set_hilo(32'h55, 32'h66);
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7; @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", {63'h0, busy}, 64'h1);
    reset = 1'b0; #1;
    check("rstmid_busy", {63'h0, busy}, 64'h0);
    check("rstmid_hi",   {32'h0, hi},   64'h0);
    check("rstmid_lo",   {32'h0, lo},   64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("rstmid_lo_later", {32'h0, lo}, 64'h0);

    // Narrow, short-latency instance
    run16("w16_multu_max",  MDU_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1);
    run16("w16_div_neg7_2", MDU_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 3);
    run16("w16_div_zero",   MDU_DIV,   16'h0009, 16'h0000, 16'hFFFF, 16'hFFFD, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
